// File: rtl/sbox_bank_sched.sv
// sbox_bank_sched: shares one 4-lane AES S-box bank between 128-bit SubBytes and 32-bit SubWord.
// Define SBOX_PIPE_EN to register the bank outputs (result latency 2 instead of 1).
module sbox_bank_sched #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned NWORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dp_start,
    input  logic [32*NWORDS-1:0]  dp_state,
    output logic                  dp_busy,
    output logic                  dp_done,
    output logic [32*NWORDS-1:0]  dp_result,
    input  logic                  ks_req,
    input  logic [31:0]           ks_word,
    output logic                  ks_gnt,
    output logic                  ks_valid,
    output logic [31:0]           ks_result
);
    localparam int unsigned IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t                    state_q;
    logic [IW-1:0]             widx_q;
    logic                      rr_ks_q;
    logic [NWORDS-1:0][31:0]   word_q;
    logic [NWORDS-1:0][31:0]   res_q;

    logic                      dp_want, gnt_dp, gnt_ks;
    logic [31:0]               iss_word, iss_sub;
    logic                      wb_vld, wb_ks;
    logic [IW-1:0]             wb_idx;
    logic [31:0]               wb_sub;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as a^254 (0 maps to 0), followed by the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        dp_want  = (state_q == StRun);
        gnt_ks   = rst_n && ks_req && (!dp_want || rr_ks_q);
        gnt_dp   = rst_n && dp_want && (!ks_req || !rr_ks_q);
        iss_word = gnt_dp ? word_q[widx_q] : ks_word;
        iss_sub  = '0;
        for (int l = 0; l < LANES; l++) begin
            iss_sub[8*l +: 8] = sbox(iss_word[8*l +: 8]);
        end
    end

    assign ks_gnt    = gnt_ks;
    assign dp_result = res_q;

`ifdef SBOX_PIPE_EN
    logic          pipe_vld_q, pipe_ks_q;
    logic [IW-1:0] pipe_idx_q;
    logic [31:0]   pipe_sub_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld_q <= 1'b0;
            pipe_ks_q  <= 1'b0;
            pipe_idx_q <= '0;
            pipe_sub_q <= '0;
        end else begin
            pipe_vld_q <= gnt_dp | gnt_ks;
            pipe_ks_q  <= gnt_ks;
            pipe_idx_q <= widx_q;
            pipe_sub_q <= iss_sub;
        end
    end

    assign wb_vld = pipe_vld_q;
    assign wb_ks  = pipe_ks_q;
    assign wb_idx = pipe_idx_q;
    assign wb_sub = pipe_sub_q;
`else
    assign wb_vld = gnt_dp | gnt_ks;
    assign wb_ks  = gnt_ks;
    assign wb_idx = widx_q;
    assign wb_sub = iss_sub;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            widx_q    <= '0;
            rr_ks_q   <= 1'b1;
            word_q    <= '0;
            res_q     <= '0;
            dp_busy   <= 1'b0;
            dp_done   <= 1'b0;
            ks_valid  <= 1'b0;
            ks_result <= '0;
        end else begin
            dp_done  <= 1'b0;
            ks_valid <= 1'b0;
            if (dp_want && ks_req) rr_ks_q <= !rr_ks_q;
            if (gnt_dp) widx_q <= (widx_q == LAST) ? '0 : widx_q + 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (dp_start) begin
                        state_q <= StRun;
                        word_q  <= dp_state;
                        dp_busy <= 1'b1;
                    end
                end
                StRun: begin
                    if (gnt_dp && widx_q == LAST) state_q <= StDrain;
                end
                StDrain: begin
                    // Stay busy through the done cycle so a start there is ignored.
                    if (dp_done) begin
                        state_q <= StIdle;
                        dp_busy <= 1'b0;
                        widx_q  <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (wb_vld) begin
                if (wb_ks) begin
                    ks_valid  <= 1'b1;
                    ks_result <= wb_sub;
                end else begin
                    res_q[wb_idx] <= wb_sub;
                    if (wb_idx == LAST) dp_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sbox_bank_sched.sv
// Directed bench for sbox_bank_sched: table-based S-box model, result scoreboards per requester.
// Honours SBOX_PIPE_EN to select the expected latency.
module tb_sbox_bank_sched;
`ifdef SBOX_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic         dp_start;
    logic [127:0] dp_state;
    logic         dp_busy, dp_done;
    logic [127:0] dp_result;
    logic         ks_req;
    logic [31:0]  ks_word;
    logic         ks_gnt, ks_valid;
    logic [31:0]  ks_result;

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    int cyc = 0;
    logic [127:0] dp_q[$];
    logic [31:0]  ks_q[$];

    sbox_bank_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dp_start  (dp_start),
        .dp_state  (dp_state),
        .dp_busy   (dp_busy),
        .dp_done   (dp_done),
        .dp_result (dp_result),
        .ks_req    (ks_req),
        .ks_word   (ks_word),
        .ks_gnt    (ks_gnt),
        .ks_valid  (ks_valid),
        .ks_result (ks_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(input string tag, input logic [127:0] obs,
                                input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = SBOX[w[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = sub_word(s[32*i +: 32]);
        return r;
    endfunction

    // Scoreboard: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ks_valid) begin
            if (ks_q.size() == 0) chk("ks_valid_unexpected", 128'(ks_valid), 128'(0));
            else chk("ks_result", 128'(ks_result), 128'(ks_q.pop_front()));
        end
        if (dp_done) begin
            n_done++;
            if (dp_q.size() == 0) chk("dp_done_unexpected", 128'(dp_done), 128'(0));
            else chk("dp_result", dp_result, dp_q.pop_front());
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input bit ks, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ks ? ks_valid : dp_done) begin
                at = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    logic [127:0] st1, st2, st3;
    logic [31:0]  kw [4];
    int k, at, d0, idx;

    initial begin
        kw = '{32'h01234567, 32'h89abcdef, 32'hdeadbeef, 32'h00ff10e0};
        st1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        st2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        st3 = {$urandom(), $urandom(), $urandom(), $urandom()};

        // Reset: grant suppressed, outputs cleared.
        rst_n = 1'b0; dp_start = 1'b0; dp_state = '0; ks_req = 1'b1; ks_word = 32'h0153ff00;
        next(); next();
        @(negedge clk);
        chk("rst_ks_gnt", 128'(ks_gnt), 128'(0));
        chk("rst_dp_busy", 128'(dp_busy), 128'(0));
        chk("rst_dp_done", 128'(dp_done), 128'(0));
        chk("rst_ks_valid", 128'(ks_valid), 128'(0));
        chk("rst_dp_result", dp_result, 128'(0));
        chk("rst_ks_result", 128'(ks_result), 128'(0));
        ks_req = 1'b0;
        next();
        rst_n = 1'b1;
        next();

        // Standalone KS.
        ks_req = 1'b1; ks_word = 32'h0153ff00;
        @(negedge clk);
        k = cyc;
        chk("ks_gnt_idle", 128'(ks_gnt), 128'(1));
        ks_q.push_back(32'h7ced1663);
        next();
        ks_req = 1'b0;
        wait_for(1'b1, at);
        chk("ks_latency", 128'(at - k), 128'(LAT));
        next();

        // Standalone DP on an all-zero state.
        dp_start = 1'b1; dp_state = '0;
        @(negedge clk);
        k = cyc;
        dp_q.push_back({16{8'h63}});
        next();
        dp_start = 1'b0;
        @(negedge clk);
        chk("dp_busy_first", 128'(dp_busy), 128'(1));
        next();
        wait_for(1'b0, at);
        chk("dp_done_lat", 128'(at - k), 128'(4 + LAT));
        chk("dp_busy_done", 128'(dp_busy), 128'(1));
        next();
        @(negedge clk);
        chk("dp_busy_after", 128'(dp_busy), 128'(0));
        chk("dp_done_pulse", 128'(dp_done), 128'(0));
        next();

        // Contention: KS requests from the first RUN cycle; grants must alternate.
        dp_start = 1'b1; dp_state = st1;
        @(negedge clk);
        k = cyc;
        dp_q.push_back(sub_state(st1));
        next();
        dp_start = 1'b0;
        idx = 0;
        for (int c = 1; c <= 8; c++) begin
            ks_req  = (idx < 4);
            ks_word = (idx < 4) ? kw[idx] : 32'h0;
            @(negedge clk);
            chk("ks_gnt_alt", 128'(ks_gnt), 128'(c % 2));
            if (ks_gnt && idx < 4) begin
                ks_q.push_back(sub_word(kw[idx]));
                idx++;
            end
            next();
        end
        ks_req = 1'b0;
        wait_for(1'b0, at);
        chk("contention_done_lat", 128'(at - k), 128'(8 + LAT));
        next();
        next();

        // Start during RUN is ignored.
        d0 = n_done;
        dp_start = 1'b1; dp_state = st2;
        @(negedge clk);
        k = cyc;
        dp_q.push_back(sub_state(st2));
        next();
        dp_start = 1'b0;
        next();
        dp_start = 1'b1; dp_state = st3;
        next();
        dp_start = 1'b0;
        wait_for(1'b0, at);
        chk("ignored_start_lat", 128'(at - k), 128'(4 + LAT));
        for (int i = 0; i < 8; i++) next();
        chk("ignored_start_one_done", 128'(n_done - d0), 128'(1));

        // Start in the done cycle is ignored; one cycle later it is accepted.
        dp_start = 1'b1; dp_state = st1;
        dp_q.push_back(sub_state(st1));
        next();
        dp_start = 1'b0;
        wait_for(1'b0, at);
        dp_start = 1'b1; dp_state = st2;
        next();
        dp_state = st3;
        @(negedge clk);
        k = cyc;
        dp_q.push_back(sub_state(st3));
        chk("busy_idle_after_done", 128'(dp_busy), 128'(0));
        next();
        dp_start = 1'b0;
        @(negedge clk);
        chk("busy_after_accept", 128'(dp_busy), 128'(1));
        next();
        wait_for(1'b0, at);
        chk("late_start_lat", 128'(at - k), 128'(4 + LAT));
        next();
        next();

        // Reset after word 2 issues: in-flight work dropped, outputs cleared.
        d0 = n_done;
        dp_start = 1'b1; dp_state = st2;
        next();
        dp_start = 1'b0;
        next(); next(); next();
        rst_n = 1'b0; ks_req = 1'b1; ks_word = 32'h11223344;
        @(negedge clk);
        chk("rst_mid_ks_gnt", 128'(ks_gnt), 128'(0));
        next();
        rst_n = 1'b1; ks_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_dp_busy", 128'(dp_busy), 128'(0));
        chk("rst_mid_dp_done", 128'(dp_done), 128'(0));
        chk("rst_mid_ks_valid", 128'(ks_valid), 128'(0));
        chk("rst_mid_dp_result", dp_result, 128'(0));
        chk("rst_mid_ks_result", 128'(ks_result), 128'(0));
        for (int i = 0; i < 8; i++) next();
        chk("rst_mid_no_done", 128'(n_done - d0), 128'(0));

        // Fresh operation after reset.
        dp_start = 1'b1; dp_state = st3 ^ st1;
        @(negedge clk);
        k = cyc;
        dp_q.push_back(sub_state(st3 ^ st1));
        next();
        dp_start = 1'b0;
        wait_for(1'b0, at);
        chk("post_rst_lat", 128'(at - k), 128'(4 + LAT));
        for (int i = 0; i < 4; i++) next();

        chk("dp_q_drained", 128'(dp_q.size()), 128'(0));
        chk("ks_q_drained", 128'(ks_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
